id_stage_pipelined: RTL and testbench
=====================================

Name: id_stage_pipelined

Overview:
- Parametrised instruction-decode stage: a multi-port register file, destination-register select, and an immediate extender with sign or zero mode.
- Adds an ID/EX pipeline register with valid tracking, write-back-to-read bypass, load-use hazard detection with bubble insertion, and flush.
- Sits between the IF/ID latch and EX. Drives a stall back to IF.

Parameters:
- DATA_WIDTH, 16, register and datapath width
- REG_ADDR_WIDTH, 3, register index width; NUM_REGS = 2**REG_ADDR_WIDTH
- IMM_WIDTH, 6, raw immediate width (must be < DATA_WIDTH)
- FUNCT_WIDTH, 2, funct field width
- ZERO_REG, 1, 1 = r0 reads 0 and ignores writes

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  IF/ID holds a valid instruction
- rs  in  REG_ADDR_WIDTH  source register 1
- rt  in  REG_ADDR_WIDTH  source register 2
- rd  in  REG_ADDR_WIDTH  R-type destination
- funct  in  FUNCT_WIDTH  ALU function, passed through
- imm  in  IMM_WIDTH  raw immediate
- imm_signed  in  1  1 = sign-extend, 0 = zero-extend
- reg_dst  in  1  1 = dest is rd, 0 = dest is rt
- reg_write  in  1  instruction writes a register
- mem_read  in  1  instruction is a load
- flush  in  1  squash the instruction entering ID/EX
- wb_we  in  1  write-back enable
- wb_addr  in  REG_ADDR_WIDTH  write-back register
- wb_data  in  DATA_WIDTH  write-back data
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- out_valid  out  1  ID/EX holds a valid instruction
- out_rs_data  out  DATA_WIDTH  registered rs value
- out_rt_data  out  DATA_WIDTH  registered rt value
- out_imm  out  DATA_WIDTH  registered extended immediate
- out_dest  out  REG_ADDR_WIDTH  registered destination index
- out_funct  out  FUNCT_WIDTH  registered funct
- out_reg_write  out  1  registered reg_write, forced 0 when not valid
- out_mem_read  out  1  registered mem_read, forced 0 when not valid

Behaviour:
- Reset (reset_n = 0, asynchronous):
  - All register-file entries clear to 0.
  - All outputs clear to 0, including out_valid and stall.
- Register file:
  - Write happens on the rising edge when wb_we = 1.
  - With ZERO_REG = 1, writes to index 0 are dropped and reads of index 0 return 0.
  - Two combinational read ports.
- Bypass: if wb_we = 1, wb_addr equals the read index, and the index is writable, the read port returns wb_data in the same cycle.
- Dest select: dest = reg_dst ? rd : rt.
- Extension:
  - imm_signed = 1: replicate imm[IMM_WIDTH-1] into the upper DATA_WIDTH-IMM_WIDTH bits.
  - imm_signed = 0: fill the upper bits with 0.
- Hazard:
  - hazard = in_valid & out_valid & out_mem_read & (out_dest != 0 or ZERO_REG = 0) & (out_dest == rs or out_dest == rt).
  - stall = hazard & ~flush.
- ID/EX update on each rising edge, in priority order:
  1. flush: out_valid <= 0 and control outputs <= 0. Data outputs are don't-care but hold.
  2. hazard: insert a bubble. out_valid, out_reg_write and out_mem_read <= 0. IF/ID is held by stall, so the same instruction re-decodes next cycle.
  3. Otherwise: capture all fields. out_valid <= in_valid. Controls are gated by in_valid.
- A hazard stalls for exactly one cycle, because the bubble clears out_mem_read.
- Latency: 1 cycle from the ID inputs to the ID/EX outputs.
- Simultaneous write-back and decode of the same register: the decoded instruction captures wb_data through the bypass.
- Reset asserted mid-stall: stall drops immediately (asynchronous) and the pipeline restarts empty.

Decomposition:
- Package id_pkg holds:
  - default width constants
  - the ID/EX bundle struct (valid, rs_data, rt_data, imm, dest, funct, reg_write, mem_read)
  - the extend-mode constants
- One sub-module, register_file, parametrised by DATA_WIDTH, REG_ADDR_WIDTH and ZERO_REG. It owns storage, reset clear, bypass and the r0 rule.
- Hazard logic, extender and pipeline register stay in id_stage_pipelined.

Test Plan:
- Write-then-read: wb r3 = 0x1234; next cycle decode rs = 3 -> out_rs_data = 0x1234 one cycle later.
- Bypass: same cycle wb r5 = 0xBEEF and decode rt = 5 -> out_rt_data = 0xBEEF, no stall.
- Extension:
  - imm = 6'b100001, signed -> out_imm = 0xFFE1.
  - Same imm, unsigned -> out_imm = 0x0021.
- Load-use: load with reg_dst = 0, rt = 2 in ID/EX; next instruction rs = 2 -> stall = 1 for one cycle, bubble (out_valid = 0), then the instruction issues with out_valid = 1.
- r0 and flush:
  - wb r0 = 0xFFFF, then read r0 -> 0.
  - Load dest r0 followed by a use of r0 -> no stall.
  - flush = 1 with in_valid = 1 -> out_valid = 0 and out_reg_write = 0 next cycle.
- Async reset: drop reset_n mid-hazard between clock edges -> outputs and stall go to 0 immediately; all registers read 0 after release.

Source files
------------

// File: rtl/id_pkg.sv
// Shared widths, extend-mode encodings and the ID/EX bundle for the decode stage.
// The bundle here is the default-width view used by consumers of ID/EX.
package id_pkg;

  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_REG_ADDR_WIDTH = 3;
  localparam int DEF_IMM_WIDTH      = 6;
  localparam int DEF_FUNCT_WIDTH    = 2;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  typedef struct packed {
    logic                          valid;
    logic [DEF_DATA_WIDTH-1:0]     rs_data;
    logic [DEF_DATA_WIDTH-1:0]     rt_data;
    logic [DEF_DATA_WIDTH-1:0]     imm;
    logic [DEF_REG_ADDR_WIDTH-1:0] dest;
    logic [DEF_FUNCT_WIDTH-1:0]    funct;
    logic                          reg_write;
    logic                          mem_read;
  } id_ex_t;

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bus: IF/ID fields and write-back in, ID/EX bundle and stall out.
// master drives the instruction side, slave is the decode stage itself.
interface id_stage_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int IMM_WIDTH      = 6,
  parameter int FUNCT_WIDTH    = 2
);
  logic                      in_valid;
  logic [REG_ADDR_WIDTH-1:0] rs;
  logic [REG_ADDR_WIDTH-1:0] rt;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [FUNCT_WIDTH-1:0]    funct;
  logic [IMM_WIDTH-1:0]      imm;
  logic                      imm_signed;
  logic                      reg_dst;
  logic                      reg_write;
  logic                      mem_read;
  logic                      flush;
  logic                      wb_we;
  logic [REG_ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic                      stall;
  logic                      out_valid;
  logic [DATA_WIDTH-1:0]     out_rs_data;
  logic [DATA_WIDTH-1:0]     out_rt_data;
  logic [DATA_WIDTH-1:0]     out_imm;
  logic [REG_ADDR_WIDTH-1:0] out_dest;
  logic [FUNCT_WIDTH-1:0]    out_funct;
  logic                      out_reg_write;
  logic                      out_mem_read;

  modport master (
    output in_valid, rs, rt, rd, funct, imm, imm_signed, reg_dst, reg_write, mem_read,
    output flush, wb_we, wb_addr, wb_data,
    input  stall, out_valid, out_rs_data, out_rt_data, out_imm, out_dest, out_funct,
    input  out_reg_write, out_mem_read
  );

  modport slave (
    input  in_valid, rs, rt, rd, funct, imm, imm_signed, reg_dst, reg_write, mem_read,
    input  flush, wb_we, wb_addr, wb_data,
    output stall, out_valid, out_rs_data, out_rt_data, out_imm, out_dest, out_funct,
    output out_reg_write, out_mem_read
  );
endinterface

// File: rtl/id_stage_pipelined_regfile.sv
// Register file: 1 write port, 2 combinational read ports with same-cycle write-back bypass.
// Writes land on the rising edge; optional hard-wired zero register.
module register_file #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int ZERO_REG       = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      we,
  input  logic [REG_ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [REG_ADDR_WIDTH-1:0] raddr0,
  input  logic [REG_ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0]     rdata0,
  output logic [DATA_WIDTH-1:0]     rdata1
);
  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];

  function automatic logic writable(input logic [REG_ADDR_WIDTH-1:0] a);
    return !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Bypass lets an instruction decoded alongside its producer's write-back see the new value.
  function automatic logic [DATA_WIDTH-1:0] rd_port(input logic [REG_ADDR_WIDTH-1:0] a);
    if (!writable(a))
      return '0;
    else if (we && (waddr == a))
      return wdata;
    else
      return mem_q[a];
  endfunction

  always_comb begin
    mem_d = mem_q;
    if (we && writable(waddr))
      mem_d[waddr] = wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata0 = rd_port(raddr0);
  assign rdata1 = rd_port(raddr1);
endmodule

// File: rtl/id_stage_pipelined.sv
// Decode stage: regfile read, dest select, immediate extend, ID/EX register (1-cycle latency).
// Load-use hazard inserts one bubble and raises stall to hold IF/ID; flush squashes the entry.
module id_stage_pipelined
  import id_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int IMM_WIDTH      = DEF_IMM_WIDTH,
  parameter int FUNCT_WIDTH    = DEF_FUNCT_WIDTH,
  parameter int ZERO_REG       = 1
) (
  input logic       clock,
  input logic       reset_n,
  id_stage_if.slave bus
);
  typedef struct packed {
    logic                      valid;
    logic [DATA_WIDTH-1:0]     rs_data;
    logic [DATA_WIDTH-1:0]     rt_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] dest;
    logic [FUNCT_WIDTH-1:0]    funct;
    logic                      reg_write;
    logic                      mem_read;
  } bundle_t;

  bundle_t                   idex_d, idex_q;
  logic [DATA_WIDTH-1:0]     rs_data, rt_data, imm_ext;
  logic [REG_ADDR_WIDTH-1:0] dest;
  logic                      ext_bit, hazard;

  register_file #(
    .DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .ZERO_REG(ZERO_REG)
  ) u_rf (
    .clock(clock), .reset_n(reset_n),
    .we(bus.wb_we), .waddr(bus.wb_addr), .wdata(bus.wb_data),
    .raddr0(bus.rs), .raddr1(bus.rt), .rdata0(rs_data), .rdata1(rt_data)
  );

  assign dest    = bus.reg_dst ? bus.rd : bus.rt;
  assign ext_bit = (bus.imm_signed == EXT_SIGN) ? bus.imm[IMM_WIDTH-1] : 1'b0;
  assign imm_ext = {{(DATA_WIDTH-IMM_WIDTH){ext_bit}}, bus.imm};

  // A load into the zero register produces nothing a consumer could wait on.
  assign hazard = bus.in_valid && idex_q.valid && idex_q.mem_read &&
                  ((idex_q.dest != '0) || (ZERO_REG == 0)) &&
                  ((idex_q.dest == bus.rs) || (idex_q.dest == bus.rt));

  always_comb begin
    idex_d = idex_q;
    if (bus.flush || hazard) begin
      idex_d.valid     = 1'b0;
      idex_d.reg_write = 1'b0;
      idex_d.mem_read  = 1'b0;
    end else begin
      idex_d.valid     = bus.in_valid;
      idex_d.rs_data   = rs_data;
      idex_d.rt_data   = rt_data;
      idex_d.imm       = imm_ext;
      idex_d.dest      = dest;
      idex_d.funct     = bus.funct;
      idex_d.reg_write = bus.in_valid && bus.reg_write;
      idex_d.mem_read  = bus.in_valid && bus.mem_read;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      idex_q <= '0;
    else
      idex_q <= idex_d;
  end

  assign bus.stall         = hazard && !bus.flush;
  assign bus.out_valid     = idex_q.valid;
  assign bus.out_rs_data   = idex_q.rs_data;
  assign bus.out_rt_data   = idex_q.rt_data;
  assign bus.out_imm       = idex_q.imm;
  assign bus.out_dest      = idex_q.dest;
  assign bus.out_funct     = idex_q.funct;
  assign bus.out_reg_write = idex_q.reg_write;
  assign bus.out_mem_read  = idex_q.mem_read;
endmodule

// File: tb/tb_id_stage_pipelined.sv
// Bench for id_stage_pipelined: directed literal cases plus randomized traffic against a behavioural model.
module tb_id_stage_pipelined;
  import id_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  id_stage_if #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(3), .IMM_WIDTH(6), .FUNCT_WIDTH(2)) bus ();

  id_stage_pipelined #(
    .DATA_WIDTH(16), .REG_ADDR_WIDTH(3), .IMM_WIDTH(6), .FUNCT_WIDTH(2), .ZERO_REG(1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  bit     check_en = 0;
  id_ex_t m;
  logic [15:0] m_regs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [2:0] a);
    if (a == 3'd0) return 16'h0;
    if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
    return m_regs[a];
  endfunction

  function automatic logic [15:0] m_ext(input logic [5:0] v, input logic s);
    int x;
    x = int'(v);
    if (s && x >= 32) x = x - 64;
    return 16'(x);
  endfunction

  function automatic logic m_hazard();
    return bus.in_valid && m.valid && m.mem_read && (m.dest != 3'd0) &&
           (m.dest == bus.rs || m.dest == bus.rt);
  endfunction

  function automatic logic m_stall();
    return m_hazard() && !bus.flush;
  endfunction

  // Behavioural model of the ID/EX contents and architectural registers.
  always @(posedge clock or negedge reset_n) begin
    id_ex_t n;
    if (!reset_n) begin
      m = '0;
      foreach (m_regs[i]) m_regs[i] = 16'h0;
    end else begin
      n = m;
      if (bus.flush || m_hazard()) begin
        n.valid = 1'b0; n.reg_write = 1'b0; n.mem_read = 1'b0;
      end else begin
        n.valid     = bus.in_valid;
        n.rs_data   = m_read(bus.rs);
        n.rt_data   = m_read(bus.rt);
        n.imm       = m_ext(bus.imm, bus.imm_signed);
        n.dest      = bus.reg_dst ? bus.rd : bus.rt;
        n.funct     = bus.funct;
        n.reg_write = bus.in_valid && bus.reg_write;
        n.mem_read  = bus.in_valid && bus.mem_read;
      end
      if (bus.wb_we && bus.wb_addr != 3'd0) m_regs[bus.wb_addr] = bus.wb_data;
      m = n;
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      chk("stall", 32'(bus.stall), 32'(m_stall()));
      chk("out_valid", 32'(bus.out_valid), 32'(m.valid));
      chk("out_reg_write", 32'(bus.out_reg_write), 32'(m.reg_write));
      chk("out_mem_read", 32'(bus.out_mem_read), 32'(m.mem_read));
      if (m.valid) begin
        chk("out_rs_data", 32'(bus.out_rs_data), 32'(m.rs_data));
        chk("out_rt_data", 32'(bus.out_rt_data), 32'(m.rt_data));
        chk("out_imm", 32'(bus.out_imm), 32'(m.imm));
        chk("out_dest", 32'(bus.out_dest), 32'(m.dest));
        chk("out_funct", 32'(bus.out_funct), 32'(m.funct));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_nop();
    bus.in_valid = 0; bus.rs = 0; bus.rt = 0; bus.rd = 0; bus.funct = 0; bus.imm = 0;
    bus.imm_signed = 0; bus.reg_dst = 0; bus.reg_write = 0; bus.mem_read = 0; bus.flush = 0;
  endtask

  task automatic set_wb(input logic we, input logic [2:0] a, input logic [15:0] d);
    bus.wb_we = we; bus.wb_addr = a; bus.wb_data = d;
  endtask

  task automatic set_instr(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                           input logic rdst, input logic ld);
    bus.in_valid = 1; bus.rs = rs; bus.rt = rt; bus.rd = rd; bus.reg_dst = rdst;
    bus.reg_write = 1; bus.mem_read = ld; bus.flush = 0;
  endtask

  initial begin
    bit hold;
    set_nop();
    set_wb(0, 0, 0);
    #3;
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_stall", 32'(bus.stall), 0);
    chk("reset_out_rs_data", 32'(bus.out_rs_data), 0);
    #9 reset_n = 1;
    check_en = 1;
    tick();

    // Write r3, then read it back through the regfile.
    set_wb(1, 3, 16'h1234);
    tick();
    set_wb(0, 0, 0);
    set_instr(3, 0, 1, 1, 0);
    tick();
    chk("wr_then_rd", 32'(bus.out_rs_data), 32'h1234);
    chk("wr_then_rd_valid", 32'(bus.out_valid), 1);

    // Same-cycle write-back bypass plus signed extension.
    set_wb(1, 5, 16'hBEEF);
    set_instr(3, 5, 1, 1, 0);
    bus.imm = 6'b100001; bus.imm_signed = 1;
    #1 chk("bypass_no_stall", 32'(bus.stall), 0);
    tick();
    chk("bypass_rt", 32'(bus.out_rt_data), 32'hBEEF);
    chk("imm_signed", 32'(bus.out_imm), 32'hFFE1);
    set_wb(0, 0, 0);
    bus.imm_signed = 0;
    tick();
    chk("imm_unsigned", 32'(bus.out_imm), 32'h0021);

    // Load-use: load to r2 followed by a consumer of r2.
    set_instr(0, 2, 0, 0, 1);
    tick();
    chk("load_dest", 32'(bus.out_dest), 2);
    chk("load_mem_read", 32'(bus.out_mem_read), 1);
    set_instr(2, 0, 4, 1, 0);
    #1 chk("lu_stall", 32'(bus.stall), 1);
    tick();
    chk("lu_bubble", 32'(bus.out_valid), 0);
    #1 chk("lu_stall_once", 32'(bus.stall), 0);
    tick();
    chk("lu_issue_valid", 32'(bus.out_valid), 1);
    chk("lu_issue_dest", 32'(bus.out_dest), 4);

    // r0 ignores writes and never creates a load-use hazard.
    set_nop();
    set_wb(1, 0, 16'hFFFF);
    tick();
    set_wb(0, 0, 0);
    set_instr(0, 0, 1, 1, 0);
    tick();
    chk("r0_reads_zero", 32'(bus.out_rs_data), 0);
    set_instr(0, 0, 0, 0, 1);
    tick();
    set_instr(0, 0, 1, 1, 0);
    #1 chk("r0_no_stall", 32'(bus.stall), 0);
    tick();
    chk("r0_use_valid", 32'(bus.out_valid), 1);

    // Flush squashes the entering instruction.
    set_instr(1, 2, 3, 1, 0);
    bus.flush = 1;
    tick();
    chk("flush_valid", 32'(bus.out_valid), 0);
    chk("flush_reg_write", 32'(bus.out_reg_write), 0);

    // Async reset in the middle of a hazard.
    set_instr(0, 6, 0, 0, 1);
    tick();
    set_instr(6, 0, 1, 1, 0);
    #1 chk("ar_stall_before", 32'(bus.stall), 1);
    #1 reset_n = 0;
    #1;
    chk("ar_stall", 32'(bus.stall), 0);
    chk("ar_valid", 32'(bus.out_valid), 0);
    chk("ar_mem_read", 32'(bus.out_mem_read), 0);
    chk("ar_dest", 32'(bus.out_dest), 0);
    set_nop();
    reset_n = 1;
    for (int i = 0; i < 8; i++) begin
      set_instr(3'(i), 3'(7 - i), 1, 1, 0);
      tick();
      chk("post_reset_rs", 32'(bus.out_rs_data), 0);
      chk("post_reset_rt", 32'(bus.out_rt_data), 0);
    end

    // Randomized traffic; IF/ID is held while the model says stall.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        bus.in_valid   = ($urandom_range(0, 9) < 8);
        bus.rs         = 3'($urandom);
        bus.rt         = 3'($urandom);
        bus.rd         = 3'($urandom);
        bus.funct      = 2'($urandom);
        bus.imm        = 6'($urandom);
        bus.imm_signed = 1'($urandom);
        bus.reg_dst    = 1'($urandom);
        bus.reg_write  = 1'($urandom);
        bus.mem_read   = ($urandom_range(0, 9) < 3);
      end
      bus.flush = ($urandom_range(0, 9) == 0);
      set_wb(1'($urandom), 3'($urandom), 16'($urandom));
      hold = m_stall();
      tick();
    end

    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
